// File: rtl/feature_pkg.sv
// Constants, frame state type and STATUS-word layout shared by the feature frame
// transmitter and any host-side decoder model.
package feature_pkg;

  localparam int FEAT_WIDTH = 32;
  localparam logic [31:0] SYNC_WORD = 32'hA5A5_5AC3;
  localparam int FRAME_WORDS = 9;
  // Frame = sync + features + status + checksum
  localparam int NUM_FEAT = FRAME_WORDS - 3;

  localparam int STATUS_STIM_LSB = 0;
  localparam int STATUS_DROP_LSB = 8;
  localparam int STATUS_ID_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FEAT,
    ST_STATUS,
    ST_CSUM
  } frame_state_e;

  function automatic logic [31:0] pack_status(input logic [15:0] id,
                                              input logic [7:0] drops,
                                              input logic stim);
    logic [31:0] s;
    s = '0;
    s[STATUS_ID_LSB +: 16] = id;
    s[STATUS_DROP_LSB +: 8] = drops;
    s[STATUS_STIM_LSB] = stim;
    return s;
  endfunction

endpackage

// File: rtl/decim_tick.sv
// Counts enabled sample cycles and pulses tick on every DECIM-th one.
module decim_tick #(
  parameter int DECIM = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/feature_frame_tx.sv
// Decimated feature snapshot framer: SYNC, six features, STATUS and an XOR
// checksum streamed over a valid/ready word interface.
module feature_frame_tx #(
  parameter int FEAT_WIDTH = feature_pkg::FEAT_WIDTH,
  parameter int DECIM = 256,
  parameter logic [FEAT_WIDTH-1:0] SYNC_WORD = FEAT_WIDTH'(feature_pkg::SYNC_WORD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [FEAT_WIDTH-1:0] ll_in,
  input  logic [FEAT_WIDTH-1:0] ne_in,
  input  logic [FEAT_WIDTH-1:0] ps_in,
  input  logic [FEAT_WIDTH-1:0] theta_in,
  input  logic [FEAT_WIDTH-1:0] alpha_in,
  input  logic [FEAT_WIDTH-1:0] beta_in,
  input  logic                  stim_in,
  input  logic                  tx_ready,
  input  logic                  clr_overrun,
  output logic [FEAT_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic [15:0]           frame_id,
  output logic                  overrun
);

  import feature_pkg::*;

  frame_state_e state, state_nxt;
  logic [2:0] feat_idx, feat_idx_nxt;

  logic tick, hs, capture, drop;
  logic [FEAT_WIDTH-1:0] feat_in [NUM_FEAT];
  logic [FEAT_WIDTH-1:0] shadow [NUM_FEAT];
  logic shadow_stim;
  logic [7:0] shadow_drop;
  logic [7:0] drop_count;
  logic [15:0] next_id;
  logic [FEAT_WIDTH-1:0] status_word, csum_word;

  decim_tick #(.DECIM(DECIM)) u_decim_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  assign feat_in[0] = ll_in;
  assign feat_in[1] = ne_in;
  assign feat_in[2] = ps_in;
  assign feat_in[3] = theta_in;
  assign feat_in[4] = alpha_in;
  assign feat_in[5] = beta_in;

  // A new snapshot fits only when idle or when the checksum word leaves this cycle
  assign hs      = (state != ST_IDLE) & tx_ready;
  assign capture = tick & ((state == ST_IDLE) | ((state == ST_CSUM) & hs));
  assign drop    = tick & ~capture;

  assign status_word = FEAT_WIDTH'(pack_status(frame_id, shadow_drop, shadow_stim));

  always_comb begin
    csum_word = SYNC_WORD ^ status_word;
    for (int i = 0; i < NUM_FEAT; i++) begin
      csum_word = csum_word ^ shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      feat_idx <= '0;
    end else begin
      state    <= state_nxt;
      feat_idx <= feat_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    feat_idx_nxt = feat_idx;
    tx_valid     = (state != ST_IDLE);
    tx_last      = (state == ST_CSUM);
    tx_data      = '0;
    case (state)
      ST_IDLE: begin
        if (capture) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        tx_data = SYNC_WORD;
        if (hs) begin
          state_nxt    = ST_FEAT;
          feat_idx_nxt = '0;
        end
      end
      ST_FEAT: begin
        tx_data = shadow[feat_idx];
        if (hs) begin
          if (feat_idx == 3'(NUM_FEAT - 1)) state_nxt = ST_STATUS;
          else feat_idx_nxt = feat_idx + 3'd1;
        end
      end
      ST_STATUS: begin
        tx_data = status_word;
        if (hs) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        tx_data = csum_word;
        if (hs) state_nxt = capture ? ST_SYNC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // STATUS reports the drop count as it stood before this snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FEAT; i++) shadow[i] <= '0;
      shadow_stim <= 1'b0;
      shadow_drop <= '0;
      frame_id    <= '0;
      next_id     <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_FEAT; i++) shadow[i] <= feat_in[i];
      shadow_stim <= stim_in;
      shadow_drop <= drop_count;
      frame_id    <= next_id;
      next_id     <= next_id + 16'd1;
    end
  end

  // A drop in the same cycle as a clear still leaves a record of itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overrun    <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clr_overrun) drop_count <= 8'd1;
      else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end else if (clr_overrun) begin
      drop_count <= '0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_feature_frame_tx.sv
// Scoreboard bench for feature_frame_tx: a frame-level reference model queues
// expected words at each snapshot and a monitor compares every accepted word.
module tb_feature_frame_tx;

  import feature_pkg::*;

  localparam int DECIM = 4;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [31:0] ll_in, ne_in, ps_in, theta_in, alpha_in, beta_in;
  logic stim_in;
  logic tx_ready;
  logic clr_overrun;
  logic [31:0] tx_data;
  logic tx_valid;
  logic tx_last;
  logic [15:0] frame_id;
  logic overrun;

  int checks = 0;
  int errors = 0;

  exp_word_t exp_q[$];
  int en_cnt;
  int remaining;
  logic [7:0] m_drop;
  bit m_ovr;
  logic [15:0] m_next_id;
  logic [15:0] m_last_id;

  feature_frame_tx #(.FEAT_WIDTH(32), .DECIM(DECIM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ll_in      (ll_in),
    .ne_in      (ne_in),
    .ps_in      (ps_in),
    .theta_in   (theta_in),
    .alpha_in   (alpha_in),
    .beta_in    (beta_in),
    .stim_in    (stim_in),
    .tx_ready   (tx_ready),
    .clr_overrun(clr_overrun),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .frame_id   (frame_id),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    en_cnt    = 0;
    remaining = 0;
    m_drop    = '0;
    m_ovr     = 1'b0;
    m_next_id = '0;
    m_last_id = '0;
  endtask

  // One clock edge of the frame-level model: a frame is a block of 9 words that
  // must all be accepted before (or exactly as) the next snapshot may start.
  task automatic model_step();
    bit tick, hs, cap_ok;
    logic [31:0] w [FRAME_WORDS];
    hs   = (remaining > 0) && tx_ready;
    tick = en && (en_cnt == DECIM - 1);
    if (en) en_cnt = (en_cnt + 1) % DECIM;
    cap_ok = (remaining == 0) || (remaining == 1 && hs);
    if (hs) remaining--;
    if (tick && cap_ok) begin
      w[0] = SYNC_WORD;
      w[1] = ll_in;
      w[2] = ne_in;
      w[3] = ps_in;
      w[4] = theta_in;
      w[5] = alpha_in;
      w[6] = beta_in;
      w[7] = {m_next_id, m_drop, 7'b0, stim_in};
      w[8] = '0;
      for (int i = 0; i < FRAME_WORDS - 1; i++) w[8] = w[8] ^ w[i];
      for (int i = 0; i < FRAME_WORDS; i++) exp_q.push_back('{w[i], i == FRAME_WORDS - 1});
      remaining = FRAME_WORDS;
      m_last_id = m_next_id;
      m_next_id = m_next_id + 16'd1;
    end
    if (tick && !cap_ok) begin
      m_ovr = 1'b1;
      if (clr_overrun) m_drop = 8'd1;
      else if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end else if (clr_overrun) begin
      m_ovr  = 1'b0;
      m_drop = '0;
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else model_step();
    end
  end

  // Monitor: compare at the falling edge, where outputs and ready are settled
  initial begin
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    exp_word_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        check_output("valid", 32'(tx_valid), 32'(remaining > 0));
        check_output("frame_id", 32'(frame_id), 32'(m_last_id));
        check_output("overrun", 32'(overrun), 32'(m_ovr));
        if (tx_valid && prev_stall) begin
          check_output("stall_data", tx_data, prev_data);
          check_output("stall_last", 32'(tx_last), 32'(prev_last));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check_output("queue_nonempty", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            check_output("word", tx_data, e.data);
            check_output("last", 32'(tx_last), 32'(e.last));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_features();
    ll_in = 32'd1; ne_in = 32'd2; ps_in = 32'd3;
    theta_in = 32'd4; alpha_in = 32'd5; beta_in = 32'd6;
    stim_in = 1'b1;
  endtask

  task automatic apply_stimulus();
    en          = ($urandom_range(0, 3) != 0);
    tx_ready    = ($urandom_range(0, 9) < 7);
    clr_overrun = ($urandom_range(0, 29) == 0);
    ll_in = $urandom(); ne_in = $urandom(); ps_in = $urandom();
    theta_in = $urandom(); alpha_in = $urandom(); beta_in = $urandom();
    stim_in = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    do begin
      step();
      t++;
    end while (!tx_valid && t < 100);
    check_output(name, 32'(tx_valid), 1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (tx_valid && t < 100) begin
      step();
      t++;
    end
    check_output(name, 32'(tx_valid), 0);
  endtask

  task automatic run_frame(input bit toggle, output int cycles, output logic [31:0] csum);
    bit done = 1'b0;
    cycles = 0;
    csum = '0;
    while (!done && cycles < 64) begin
      tx_ready = toggle ? (cycles % 2 == 1) : 1'b1;
      done = tx_valid && tx_last && tx_ready;
      if (done) csum = tx_data;
      step();
      cycles++;
    end
  endtask

  initial begin
    int cycles;
    int gap;
    logic [31:0] csum;

    rst_n = 1'b0; en = 1'b0; tx_ready = 1'b1; clr_overrun = 1'b0;
    ll_in = '0; ne_in = '0; ps_in = '0; theta_in = '0; alpha_in = '0; beta_in = '0;
    stim_in = 1'b0;
    #12;
    check_output("rst_valid", 32'(tx_valid), 0);
    check_output("rst_data", tx_data, 0);
    check_output("rst_last", 32'(tx_last), 0);
    check_output("rst_id", 32'(frame_id), 0);
    check_output("rst_overrun", 32'(overrun), 0);
    step();
    rst_n = 1'b1;

    $display("[TB] basic frame");
    set_features();
    en = 1'b1;
    wait_valid("basic_start");
    en = 1'b0;
    check_output("basic_sync", tx_data, 32'hA5A5_5AC3);
    run_frame(1'b0, cycles, csum);
    check_output("basic_cycles", 32'(cycles), 9);
    check_output("basic_csum", csum, 32'hA5A5_5AC5);
    check_output("basic_id", 32'(frame_id), 0);

    $display("[TB] backpressure frame");
    en = 1'b1;
    wait_valid("bp_start");
    en = 1'b0;
    run_frame(1'b1, cycles, csum);
    check_output("bp_cycles", 32'(cycles), 18);
    tx_ready = 1'b1;

    $display("[TB] overrun");
    en = 1'b1;
    wait_valid("ovr_start");
    tx_ready = 1'b0;
    repeat (20) step();
    check_output("ovr_set", 32'(overrun), 1);
    en = 1'b0;
    tx_ready = 1'b1;
    wait_idle("ovr_drain");
    en = 1'b1;
    wait_valid("ovr_next");
    en = 1'b0;
    run_frame(1'b0, cycles, csum);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check_output("ovr_clear", 32'(overrun), 0);

    $display("[TB] back-to-back");
    en = 1'b1;
    wait_valid("b2b_start");
    for (int j = 1; j <= 9; j++) begin
      en = (j >= 6);
      step();
    end
    en = 1'b0;
    check_output("b2b_valid", 32'(tx_valid), 1);
    check_output("b2b_sync", tx_data, 32'hA5A5_5AC3);
    check_output("b2b_last", 32'(tx_last), 0);
    check_output("b2b_overrun", 32'(overrun), 0);
    wait_idle("b2b_drain");

    $display("[TB] en gating");
    en = 1'b1;
    wait_valid("gate_start");
    gap = 0;
    for (int j = 1; j <= 40 && gap == 0; j++) begin
      en = !(j >= 2 && j <= 11);
      step();
      if (j > 9 && tx_valid) gap = j;
    end
    en = 1'b0;
    check_output("gate_gap", 32'(gap), DECIM + 10);
    wait_idle("gate_drain");

    $display("[TB] random traffic");
    for (int c = 0; c < 800; c++) begin
      apply_stimulus();
      step();
    end
    en = 1'b0; clr_overrun = 1'b0; tx_ready = 1'b1;
    wait_idle("rand_drain");
    repeat (2) step();
    check_output("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] reset mid-frame");
    set_features();
    en = 1'b1;
    wait_valid("rstmid_start");
    tx_ready = 1'b0;
    repeat (12) step();
    rst_n = 1'b0;
    #1;
    check_output("rstmid_valid", 32'(tx_valid), 0);
    check_output("rstmid_data", tx_data, 0);
    check_output("rstmid_last", 32'(tx_last), 0);
    check_output("rstmid_id", 32'(frame_id), 0);
    check_output("rstmid_overrun", 32'(overrun), 0);
    en = 1'b0;
    tx_ready = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
